// File: rtl/spi_iq_pkg.sv
// Shared widths and unpacker state encoding for the SPI I/Q sample receiver.
package spi_iq_pkg;
  localparam int unsigned SAMPLE_W      = 4;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned FRAME_BYTES_W = 16;

  typedef enum logic {
    HI = 1'b0,
    LO = 1'b1
  } unpack_state_e;
endpackage

// File: rtl/spi_iq_deserializer_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; a push into a full FIFO is honoured when a pop occurs in the same cycle.
module byte_fifo
  import spi_iq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] data_i,
  input  logic              pop_i,
  output logic [BYTE_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        wr_ptr_q                <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end
endmodule

// File: rtl/spi_iq_deserializer.sv
// Mode-0 SPI slave oversampled by the MCU clock: bytes go into a FIFO and are
// unpacked high nibble first into 4-bit I/Q samples on a valid/ready port.
module spi_iq_deserializer
  import spi_iq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     MCU_CLK_25_000,
  input  logic                     RESET_P,
  input  logic                     SPI_SCK,
  input  logic                     SPI_SS,
  input  logic                     SPI_MOSI,
  output logic [SAMPLE_W-1:0]      SAMPLE,
  output logic                     SAMPLE_VALID,
  input  logic                     SAMPLE_READY,
  output logic                     FRAME_ERR,
  output logic                     OVERFLOW,
  output logic [FRAME_BYTES_W-1:0] FRAME_BYTES
);
  logic [2:0] sck_q, ss_q;
  logic [1:0] mosi_q;
  logic [1:0] warm_q;
  logic       armed_q;

  logic [2:0]               bit_cnt_q;
  logic [BYTE_W-2:0]        shift_q;
  logic [BYTE_W-1:0]        push_data_q;
  logic                     push_q;
  logic [FRAME_BYTES_W-1:0] byte_cnt_q, frame_bytes_q;
  logic                     frame_err_q, overflow_q;
  unpack_state_e            state_q;

  logic              sck_rise, ss_fall, ss_rise, in_frame;
  logic              accept, pop;
  logic              fifo_full, fifo_empty;
  logic [BYTE_W-1:0] head, byte_next;

  // A frame only counts once SS has been seen high after reset, so a reset
  // in the middle of a frame cannot fake an SS fall and resume mid-byte.
  assign sck_rise  = sck_q[1] && !sck_q[2];
  assign ss_fall   = !ss_q[1] && ss_q[2] && armed_q;
  assign ss_rise   = ss_q[1] && !ss_q[2] && armed_q;
  assign in_frame  = !ss_q[1] && armed_q;
  // Only 7 bits are stored; the 8th arrives straight from the synchronizer.
  assign byte_next = {shift_q, mosi_q[1]};

  assign SAMPLE_VALID = !fifo_empty;
  assign accept       = SAMPLE_VALID && SAMPLE_READY;
  assign pop          = accept && (state_q == LO);

  always_comb begin
    SAMPLE = '0;
    if (!fifo_empty) begin
      SAMPLE = (state_q == HI) ? head[BYTE_W-1:SAMPLE_W] : head[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET_P) begin
      sck_q   <= '0;
      ss_q    <= '1;
      mosi_q  <= '0;
      warm_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      sck_q  <= {sck_q[1:0], SPI_SCK};
      ss_q   <= {ss_q[1:0], SPI_SS};
      mosi_q <= {mosi_q[0], SPI_MOSI};
      warm_q <= {warm_q[0], 1'b1};
      if (warm_q[1] && ss_q[1]) begin
        armed_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET_P) begin
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      push_data_q   <= '0;
      push_q        <= 1'b0;
      byte_cnt_q    <= '0;
      frame_bytes_q <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      if (ss_fall) begin
        bit_cnt_q  <= '0;
        shift_q    <= '0;
        byte_cnt_q <= '0;
      end else if (ss_rise) begin
        frame_bytes_q <= byte_cnt_q;
        frame_err_q   <= (bit_cnt_q != 3'd0);
        bit_cnt_q     <= '0;
      end else if (in_frame && sck_rise) begin
        shift_q   <= byte_next[BYTE_W-2:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          push_q      <= 1'b1;
          push_data_q <= byte_next;
          if (byte_cnt_q != '1) begin
            byte_cnt_q <= byte_cnt_q + 16'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET_P) begin
      overflow_q <= 1'b0;
      state_q    <= HI;
    end else begin
      if (push_q && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
      if (accept) begin
        state_q <= (state_q == HI) ? LO : HI;
      end
    end
  end

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (MCU_CLK_25_000),
    .rst_i  (RESET_P),
    .push_i (push_q),
    .data_i (push_data_q),
    .pop_i  (pop),
    .head_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign FRAME_ERR   = frame_err_q;
  assign OVERFLOW    = overflow_q;
  assign FRAME_BYTES = frame_bytes_q;
endmodule

// File: tb/tb_spi_iq_deserializer.sv
// Directed bench for spi_iq_deserializer: frame vectors from a table plus hand-timed corner sequences.
module tb_spi_iq_deserializer;
  logic        clk = 1'b0;
  logic        RESET_P, SPI_SCK, SPI_SS, SPI_MOSI, SAMPLE_READY;
  logic [3:0]  SAMPLE;
  logic        SAMPLE_VALID, FRAME_ERR, OVERFLOW;
  logic [15:0] FRAME_BYTES;

  int total = 0;
  int bad   = 0;

  logic [3:0] got[$];
  int err_cnt = 0;
  int vld_cnt = 0;

  typedef struct {
    bit          do_reset;
    bit          hold_ready;
    int          nbytes;
    logic [63:0] bytes;
    int          xbits;
    logic [7:0]  xval;
    int          exp_fb;
    int          exp_err;
    bit          exp_ovf;
    int          exp_ns;
    logic [63:0] exp_smp;
  } vec_t;

  vec_t vecs[6];

  spi_iq_deserializer #(.FIFO_DEPTH(4)) dut (
    .MCU_CLK_25_000(clk),
    .RESET_P       (RESET_P),
    .SPI_SCK       (SPI_SCK),
    .SPI_SS        (SPI_SS),
    .SPI_MOSI      (SPI_MOSI),
    .SAMPLE        (SAMPLE),
    .SAMPLE_VALID  (SAMPLE_VALID),
    .SAMPLE_READY  (SAMPLE_READY),
    .FRAME_ERR     (FRAME_ERR),
    .OVERFLOW      (OVERFLOW),
    .FRAME_BYTES   (FRAME_BYTES)
  );

  always #20 clk = ~clk;

  always @(negedge clk) begin
    if (!RESET_P) begin
      if (SAMPLE_VALID && SAMPLE_READY) got.push_back(SAMPLE);
      if (FRAME_ERR) err_cnt++;
      if (SAMPLE_VALID) vld_cnt++;
    end
  end

  function automatic vec_t mk(bit rst, bit hold, int nb, logic [63:0] b, int xb, logic [7:0] xv,
                              int fb, int err, bit ovf, int ns, logic [63:0] ex);
    vec_t v;
    v.do_reset = rst; v.hold_ready = hold; v.nbytes = nb; v.bytes = b;
    v.xbits = xb; v.xval = xv; v.exp_fb = fb; v.exp_err = err; v.exp_ovf = ovf;
    v.exp_ns = ns; v.exp_smp = ex;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #5;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic spi_bit(input logic b);
    SPI_MOSI = b;
    ticks(3);
    SPI_SCK = 1'b1;
    ticks(3);
    SPI_SCK = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int j = 7; j >= 0; j--) spi_bit(b[j]);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".rst_sample"}, {28'd0, SAMPLE}, 32'd0);
    check({tag, ".rst_valid"}, {31'd0, SAMPLE_VALID}, 32'd0);
    check({tag, ".rst_err"}, {31'd0, FRAME_ERR}, 32'd0);
    check({tag, ".rst_ovf"}, {31'd0, OVERFLOW}, 32'd0);
    check({tag, ".rst_fb"}, {16'd0, FRAME_BYTES}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    RESET_P = 1'b1;
    tick();
    check_reset_state(tag);
    RESET_P = 1'b0;
    ticks(4);
  endtask

  task automatic check_samples(input string tag, input int g0, input int ns, input logic [63:0] ex);
    logic [3:0] a;
    check({tag, ".nsamp"}, got.size() - g0, ns);
    for (int k = 0; k < ns; k++) begin
      a = (g0 + k < got.size()) ? got[g0 + k] : 4'hx;
      check($sformatf("%s.smp%0d", tag, k), {28'd0, a}, {28'd0, ex[63 - 4*k -: 4]});
    end
  endtask

  initial begin
    int g0, e0, v0;
    logic [7:0] b;
    string tag;

    RESET_P = 1'b1; SPI_SCK = 1'b0; SPI_SS = 1'b1; SPI_MOSI = 1'b0; SAMPLE_READY = 1'b0;
    ticks(2);

    vecs[0] = mk(1, 0, 1, {8'hA5, 56'h0}, 0, 8'h00, 1, 0, 0, 2, {8'hA5, 56'h0});
    vecs[1] = mk(1, 1, 3, {24'h123456, 40'h0}, 0, 8'h00, 3, 0, 0, 6, {24'h123456, 40'h0});
    vecs[2] = mk(1, 1, 6, {48'h112233445566, 16'h0}, 0, 8'h00, 6, 0, 1, 8, {32'h11223344, 32'h0});
    vecs[3] = mk(1, 0, 0, 64'h0, 5, 8'b1011_0000, 0, 1, 0, 0, 64'h0);
    vecs[4] = mk(0, 0, 1, {8'hC3, 56'h0}, 0, 8'h00, 1, 0, 0, 2, {8'hC3, 56'h0});
    vecs[5] = mk(1, 0, 2, {16'hFF00, 48'h0}, 0, 8'h00, 2, 0, 0, 4, {16'hFF00, 48'h0});

    for (int i = 0; i < 6; i++) begin
      tag = $sformatf("vec%0d", i);
      if (vecs[i].do_reset) do_reset(tag);
      g0 = got.size(); e0 = err_cnt; v0 = vld_cnt;
      SAMPLE_READY = !vecs[i].hold_ready;
      SPI_SS = 1'b0;
      ticks(3);
      for (int n = 0; n < vecs[i].nbytes; n++) begin
        b = vecs[i].bytes[63 - 8*n -: 8];
        spi_byte(b);
      end
      for (int j = 0; j < vecs[i].xbits; j++) spi_bit(vecs[i].xval[7 - j]);
      ticks(3);
      SPI_SS = 1'b1;
      ticks(6);
      SAMPLE_READY = 1'b1;
      ticks(24);
      SAMPLE_READY = 1'b0;
      ticks(2);
      check({tag, ".frame_bytes"}, {16'd0, FRAME_BYTES}, vecs[i].exp_fb);
      check({tag, ".overflow"}, {31'd0, OVERFLOW}, {31'd0, vecs[i].exp_ovf});
      check({tag, ".err_pulses"}, err_cnt - e0, vecs[i].exp_err);
      check({tag, ".valid_seen"}, {31'd0, (vld_cnt - v0) > 0}, {31'd0, vecs[i].exp_ns > 0});
      check_samples(tag, g0, vecs[i].exp_ns, vecs[i].exp_smp);
    end

    // Reset after 4 bits; the rest of that frame must be ignored.
    do_reset("midrst");
    SAMPLE_READY = 1'b1;
    SPI_SS = 1'b0;
    ticks(3);
    spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b1);
    RESET_P = 1'b1;
    tick();
    RESET_P = 1'b0;
    check_reset_state("midrst.during");
    g0 = got.size(); e0 = err_cnt;
    spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0);
    ticks(3);
    SPI_SS = 1'b1;
    ticks(6);
    check("midrst.err_pulses", err_cnt - e0, 0);
    check("midrst.nsamp_ignored", got.size() - g0, 0);
    check("midrst.fb_ignored", {16'd0, FRAME_BYTES}, 0);
    check("midrst.valid_ignored", {31'd0, SAMPLE_VALID}, 0);
    g0 = got.size();
    SPI_SS = 1'b0;
    ticks(3);
    spi_byte(8'h7E);
    ticks(3);
    SPI_SS = 1'b1;
    ticks(12);
    check("midrst.fb_new", {16'd0, FRAME_BYTES}, 1);
    check_samples("midrst.new", g0, 2, {8'h7E, 56'h0});

    // Full FIFO in LO state: the 5th byte's push lands on the same edge as a pop.
    do_reset("pushpop");
    g0 = got.size(); e0 = err_cnt;
    SAMPLE_READY = 1'b0;
    SPI_SS = 1'b0;
    ticks(3);
    spi_byte(8'h01); spi_byte(8'h23); spi_byte(8'h45); spi_byte(8'h67);
    b = 8'h89;
    for (int j = 7; j >= 1; j--) spi_bit(b[j]);
    SAMPLE_READY = 1'b1;
    tick();
    SAMPLE_READY = 1'b0;
    SPI_MOSI = b[0];
    ticks(3);
    SPI_SCK = 1'b1;
    ticks(3);
    SAMPLE_READY = 1'b1;
    tick();
    SAMPLE_READY = 1'b0;
    ticks(2);
    SPI_SCK = 1'b0;
    ticks(3);
    SPI_SS = 1'b1;
    ticks(6);
    SAMPLE_READY = 1'b1;
    ticks(24);
    SAMPLE_READY = 1'b0;
    check("pushpop.overflow", {31'd0, OVERFLOW}, 0);
    check("pushpop.frame_bytes", {16'd0, FRAME_BYTES}, 5);
    check("pushpop.err_pulses", err_cnt - e0, 0);
    check_samples("pushpop", g0, 10, {40'h0123456789, 24'h0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad + 1);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/spi_iq_deserializer.md
# spi_iq_deserializer

Receive-side SPI slave for the GPS sample link: it reconstructs the 2-bit I / 2-bit Q GPS sample stream from the serial SCK/SS/MOSI bus that the CPLD bridge drives toward the MCU. It is used for on-board loopback and for a second CPLD acting as the MCU-side endpoint. It oversamples the asynchronous SPI lines with the 25 MHz MCU clock, deserializes bytes into a 4-entry FIFO, and unpacks each byte into two 4-bit samples on a valid/ready output.

## Interface
- FIFO_DEPTH, 4: byte entries in the receive FIFO; power of two, 2 to 16.
- MCU_CLK_25_000  in  1  sole clock; all logic on its rising edge.
- RESET_P  in  1  synchronous, active-high reset.
- SPI_SCK  in  1  asynchronous SPI clock, mode 0; idle low; data is captured on the rising edge.
- SPI_SS  in  1  asynchronous active-low frame select.
- SPI_MOSI  in  1  asynchronous serial data, MSB first.
- SAMPLE  out  4  {I0,I1,Q0,Q1}, with I0 in bit 3.
- SAMPLE_VALID  out  1  SAMPLE holds a sample.
- SAMPLE_READY  in  1  consumer accepts the sample when VALID&&READY.
- FRAME_ERR  out  1  one-cycle pulse: SS deasserted with a partial byte.
- OVERFLOW  out  1  sticky: a completed byte was dropped because the FIFO was full.
- FRAME_BYTES  out  16  byte count of the last completed frame, latched at the SS rise.

## Operation
**Synchronization**
- SCK, SS and MOSI each pass through a 2-flop synchronizer.
- A third register on SCK and SS provides edge detection.
- Data is valid only while synchronized SS is low.

**Frame**
- SS fall: clears the bit counter (3 bits), the shift register and the frame byte counter.
- SCK rise while SS low: shift register becomes {shift[6:0], MOSI_sync}; the bit counter increments.
- 8th rise: the completed byte is pushed to the FIFO and the frame byte counter increments.
  - The frame byte counter saturates at 0xFFFF.
  - The bit counter wraps to 0.
- Byte packing: bits 7:4 are sample n, bits 3:0 are sample n+1.
- SS rise:
  - FRAME_BYTES is updated with the frame byte count.
  - If the bit counter is nonzero, FRAME_ERR pulses and the partial bits are discarded.
- SCK edges while SS is high are ignored.

**FIFO**
- Storage is FIFO_DEPTH bytes with read/write pointers one bit wider than the address.
- Full means the addresses are equal and the MSBs differ.
- Push when full: the byte is dropped, OVERFLOW is set, and the frame byte counter still increments.
- OVERFLOW clears only on reset.

**Unpacker**
- Two states: HI and LO.
- SAMPLE_VALID is high whenever the FIFO is non-empty.
- HI: SAMPLE = head[7:4]. On accept, go to LO.
- LO: SAMPLE = head[3:0]. On accept, pop the head and go to HI.
- Simultaneous push and pop are both honoured in the same cycle. A push is not dropped when the FIFO is full and a pop occurs in the same cycle.

**Reset** (mid-frame or otherwise)
- FIFO empty, unpacker in HI, counters 0, the shift register discarded.
- After reset, a byte in progress is not resumed. Reception restarts at the next SS fall.

## Timing
Reset values:
- SAMPLE = 0, SAMPLE_VALID = 0, FRAME_ERR = 0, OVERFLOW = 0, FRAME_BYTES = 0.
- Synchronizer flops reset to SCK=0, SS=1, MOSI=0.

Latency:
- SCK pin rise to bit capture: 3 clocks.
- 8th SCK pin rise to SAMPLE_VALID: 4 clocks. That is 3 clocks of sync/edge detect plus 1 for the FIFO write. SAMPLE is driven combinationally from the FIFO head.

SPI clock requirements:
- SCK high and low phases must each be ≥ 2 MCU clocks, i.e. f_SCK ≤ 6.25 MHz.
- MOSI must be stable from 1 clock before to 3 clocks after the SCK rise. Under these conditions MOSI and SCK share the same synchronizer depth and remain aligned.

Status outputs:
- FRAME_ERR and the FRAME_BYTES update occur 3 clocks after the SS pin rise.

Throughput:
- The output can drain one sample per clock. This far exceeds the input rate, so overflow only occurs when the consumer stalls READY.

## Structure
- Package spi_iq_pkg holds:
  - sample width 4;
  - byte width 8;
  - unpacker state enum {HI, LO};
  - FRAME_BYTES width 16.
- One natural sub-module is byte_fifo: parameterized depth, push/pop/full/empty, head output. It is reusable elsewhere in the bridge.
- The synchronizer flops are instantiated inline or via the existing synchronizer cell.

## Test plan
- **Single byte.** SS low, send 0xA5 at 4 MHz, SS high, READY=1. Expect SAMPLE 0xA then 0x5 on consecutive cycles, FRAME_BYTES=1, no FRAME_ERR.
- **Multi-byte with backpressure.** Send 3 bytes 0x12, 0x34, 0x56 with READY held 0 until SS rises. Expect samples 1,2,3,4,5,6 in order, OVERFLOW=0, FRAME_BYTES=3.
- **Overflow.** Send 6 bytes with READY=0 and FIFO_DEPTH=4. Expect OVERFLOW=1, FRAME_BYTES=6, and only the first 4 bytes (8 samples) emitted once READY=1.
- **Partial byte.** Send 5 bits then raise SS. Expect a single-cycle FRAME_ERR pulse, no SAMPLE_VALID, and FRAME_BYTES=0. The next frame with 0xC3 yields 0xC, 0x3.
- **Reset mid-frame.** Assert RESET_P for 1 clock after 4 bits. Expect all outputs at reset values and the remaining 4 bits ignored. A new SS fall plus 0x7E yields 0x7, 0xE.
- **Simultaneous push/pop at full.** With the FIFO full and in LO state, the 8th SCK rise coincides with an accept. Expect no byte dropped, OVERFLOW=0, and order preserved.
